// File: rtl/shadowmask_gen_if.sv
// shadowmask_gen bus: command port plus the RGB video stream in/out.
// master drives commands and video; slave is the mask core.
interface shadowmask_gen_if #(
  parameter int CW = 8
);
  logic          cmd_wr;
  logic [15:0]   cmd_in;
  logic [3*CW-1:0] din;
  logic          hs_in;
  logic          vs_in;
  logic          de_in;
  logic          enable;
  logic [3*CW-1:0] dout;
  logic          hs_out;
  logic          vs_out;
  logic          de_out;

  modport master (
    output cmd_wr, cmd_in, din,
    output hs_in, vs_in, de_in, enable,
    input  dout, hs_out, vs_out, de_out
  );

  modport slave (
    input  cmd_wr, cmd_in, din,
    input  hs_in, vs_in, de_in, enable,
    output dout, hs_out, vs_out, de_out
  );
endinterface

// File: rtl/shadowmask_gen.sv
// shadowmask_gen: 2D shadow mask with per-cell gain, rotation, 1x..4x scale.
// Define SHADOWMASK_VSYNC_LATCH_EN to latch config on vsync falling edge.
module shadowmask_gen #(
  parameter int CW = 8,
  parameter int MB = 3,
  parameter int GW = 5
) (
  input logic clk,
  input logic reset,
  shadowmask_gen_if.slave bus
);

  localparam int AW = 2 * MB;
  localparam int PW = CW + GW;
  localparam logic [GW-1:0] G16 = GW'(16);
  localparam logic [CW-1:0] MAXV = '1;

  typedef struct packed {
    logic          men;
    logic          rot;
    logic [1:0]    sc;
    logic [MB-1:0] hmax;
    logic [MB-1:0] vmax;
    logic [GW-1:0] on0;
    logic [GW-1:0] on1;
    logic [GW-1:0] off0;
    logic [GW-1:0] off1;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    men: 1'b0, rot: 1'b0, sc: 2'd0,
    hmax: '0, vmax: '0,
    on0: G16, on1: G16, off0: G16, off1: G16
  };

  function automatic logic [MB-1:0] clamp(input logic [3:0] v);
    if (int'(v) > (1 << MB) - 1) return MB'((1 << MB) - 1);
    return MB'(v);
  endfunction

  logic [2:0]    op;
  logic          cmd_unused;
  cfg_t          cfg;
  cfg_t          cfg_base;
  cfg_t          cfg_wr;

  logic [3:0]    lut [2**AW];

  logic [1:0]    hsub, vsub;
  logic [MB-1:0] hidx, vidx;
  logic [MB-1:0] hw, vh;
  logic [AW-1:0] addr;
  logic          hs_fall, vs_fall;

  logic [2:0][CW-1:0] pix_in;
  logic [2:0][CW-1:0] p1_pix, p2_pix;
  logic [2:0]         p1_s, p2_s, p3_s, p4_s;
  logic [3:0]         p1_ent;
  logic               p1_en;
  logic [2:0][GW-1:0] g_sel, p2_g;
  logic [2:0][PW-1:0] p3_p, shf;
  logic [2:0][CW-1:0] sat, p4_pix;

  assign op = bus.cmd_in[15:13];
  assign cmd_unused = ^bus.cmd_in;
  assign pix_in = bus.din;

  assign hs_fall = p1_s[2] & ~bus.hs_in;
  assign vs_fall = p1_s[1] & ~bus.vs_in;

`ifdef SHADOWMASK_VSYNC_LATCH_EN
  cfg_t shd;
  assign cfg_base = shd;
`else
  assign cfg_base = cfg;
`endif

  // Apply one command word on top of the writable config copy.
  always_comb begin
    cfg_wr = cfg_base;
    if (bus.cmd_wr) begin
      case (op)
        3'b000: begin
          cfg_wr.men = bus.cmd_in[0];
          cfg_wr.rot = bus.cmd_in[1];
          cfg_wr.sc  = bus.cmd_in[3:2];
        end
        3'b001: cfg_wr.vmax = clamp(bus.cmd_in[3:0]);
        3'b010: cfg_wr.hmax = clamp(bus.cmd_in[3:0]);
        3'b100: begin
          if (bus.cmd_in[8]) cfg_wr.on1 = bus.cmd_in[GW-1:0];
          else               cfg_wr.on0 = bus.cmd_in[GW-1:0];
        end
        3'b101: begin
          if (bus.cmd_in[8]) cfg_wr.off1 = bus.cmd_in[GW-1:0];
          else               cfg_wr.off0 = bus.cmd_in[GW-1:0];
        end
        default: ;
      endcase
    end
  end

  // Config registers; shadow copy goes live only on vsync fall when latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef SHADOWMASK_VSYNC_LATCH_EN
      shd <= CFG_RST;
`endif
      cfg <= CFG_RST;
    end else begin
`ifdef SHADOWMASK_VSYNC_LATCH_EN
      shd <= cfg_wr;
      if (vs_fall) cfg <= shd;
`else
      cfg <= cfg_wr;
`endif
    end
  end

  // Pattern LUT, loaded by software, intentionally not reset.
  always_ff @(posedge clk) begin
    if (bus.cmd_wr && op == 3'b011)
      lut[bus.cmd_in[4+AW-1:4]] <= bus.cmd_in[3:0];
  end

  assign hw   = cfg.rot ? cfg.vmax : cfg.hmax;
  assign vh   = cfg.rot ? cfg.hmax : cfg.vmax;
  assign addr = cfg.rot ? {hidx, vidx} : {vidx, hidx};

  // Pattern position: prescaled pixel/line counters, reset by sync edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsub <= '0;
      hidx <= '0;
      vsub <= '0;
      vidx <= '0;
    end else begin
      if (hs_fall) begin
        hsub <= '0;
        hidx <= '0;
      end else if (hsub >= cfg.sc) begin
        hsub <= '0;
        hidx <= (hidx >= hw) ? '0 : hidx + 1'b1;
      end else begin
        hsub <= hsub + 1'b1;
      end
      if (vs_fall) begin
        vsub <= '0;
        vidx <= '0;
      end else if (hs_fall) begin
        if (vsub >= cfg.sc) begin
          vsub <= '0;
          vidx <= (vidx >= vh) ? '0 : vidx + 1'b1;
        end else begin
          vsub <= vsub + 1'b1;
        end
      end
    end
  end

  // Per-channel gain pick; unity gain keeps the disabled path bit-exact.
  always_comb begin
    g_sel = '0;
    for (int c = 0; c < 3; c++) begin
      g_sel[c] = G16;
      if (p1_en) begin
        if (p1_ent[c]) g_sel[c] = p1_ent[3] ? cfg.on1 : cfg.on0;
        else           g_sel[c] = p1_ent[3] ? cfg.off1 : cfg.off0;
      end
    end
  end

  // Drop the 1/16 fraction and clip to full scale.
  always_comb begin
    shf = '0;
    sat = '0;
    for (int c = 0; c < 3; c++) begin
      shf[c] = p3_p[c] >> 4;
      sat[c] = (shf[c] > {{GW{1'b0}}, MAXV}) ? MAXV : shf[c][CW-1:0];
    end
  end

  // Four-stage pixel pipeline: LUT, gain, multiply, saturate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_pix <= '0;
      p1_s   <= '0;
      p1_ent <= '0;
      p1_en  <= 1'b0;
      p2_pix <= '0;
      p2_s   <= '0;
      p2_g   <= '0;
      p3_p   <= '0;
      p3_s   <= '0;
      p4_pix <= '0;
      p4_s   <= '0;
    end else begin
      p1_pix <= pix_in;
      p1_s   <= {bus.hs_in, bus.vs_in, bus.de_in};
      p1_ent <= lut[addr];
      p1_en  <= cfg.men & bus.enable;
      p2_pix <= p1_pix;
      p2_s   <= p1_s;
      p2_g   <= g_sel;
      for (int c = 0; c < 3; c++)
        p3_p[c] <= {{GW{1'b0}}, p2_pix[c]} * {{CW{1'b0}}, p2_g[c]};
      p3_s   <= p2_s;
      p4_pix <= sat;
      p4_s   <= p3_s;
    end
  end

  assign bus.dout   = p4_pix;
  assign bus.hs_out = p4_s[2];
  assign bus.vs_out = p4_s[1];
  assign bus.de_out = p4_s[0];

endmodule

// File: tb/tb_shadowmask_gen.sv
// tb_shadowmask_gen: directed vectors through a 4-deep expectation line.
// Covers reset, bypass, gains, pattern/scale, clamp, rotation, sync edges.
module tb_shadowmask_gen;

`ifdef SHADOWMASK_VSYNC_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  shadowmask_gen_if #(.CW(8)) bus ();

  shadowmask_gen #(.CW(8), .MB(3), .GW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int nchk = 0;

  logic [23:0] q_exp [$];
  bit          q_on  [$];
  logic [2:0]  q_sy  [$];
  string       q_tag [$];

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step(input logic [23:0] d, input logic h, input logic v,
                      input bit c, input logic [23:0] x, input string t);
    logic [23:0] ex;
    bit          on;
    logic [2:0]  sy;
    string       tg;
    if (q_exp.size() >= 4) begin
      ex = q_exp.pop_front();
      on = q_on.pop_front();
      sy = q_sy.pop_front();
      tg = q_tag.pop_front();
      if (on) chk(tg, {8'h0, bus.dout}, {8'h0, ex});
      chk("sync", {29'b0, bus.hs_out, bus.vs_out, bus.de_out},
          {29'b0, sy});
    end
    bus.din   = d;
    bus.hs_in = h;
    bus.vs_in = v;
    bus.de_in = c;
    q_exp.push_back(x);
    q_on.push_back(c);
    q_sy.push_back({h, v, c});
    q_tag.push_back(t);
    @(negedge clk);
  endtask

  task automatic idle();
    step(24'h0, 1'b1, 1'b1, 1'b0, 24'h0, "");
  endtask

  task automatic cmd(input logic [2:0] op, input logic [12:0] p);
    bus.cmd_wr = 1'b1;
    bus.cmd_in = {op, p};
    idle();
    bus.cmd_wr = 1'b0;
  endtask

  task automatic latch();
    step(24'h0, 1'b1, 1'b0, 1'b0, 24'h0, "");
    idle();
  endtask

  logic [23:0] pat3 [7];
  logic [23:0] rot_x [18];
  logic        rot_h [18];
  logic        rot_v [18];
  bit          rot_c [18];

  initial begin
    pat3 = '{24'hFF0000, 24'hFF0000, 24'h00FF00, 24'h00FF00,
             24'h0000FF, 24'h0000FF, 24'hFF0000};
    rot_h = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    rot_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    rot_c = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    rot_x = '{24'h0,     24'hFF0000, 24'hFF0000, 24'hFF0000,
              24'h00FF00, 24'h00FF00, 24'h00FF00, 24'h00FF00,
              24'h0000FF, 24'h0000FF, 24'h0000FF, 24'hFF0000,
              24'hFF0000, 24'hFF0000, 24'h00FF00, 24'h00FF00,
              24'h00FF00, 24'hFF0000};

    bus.cmd_wr = 1'b0;
    bus.cmd_in = '0;
    bus.din    = '0;
    bus.hs_in  = 1'b1;
    bus.vs_in  = 1'b1;
    bus.de_in  = 1'b0;
    bus.enable = 1'b1;
    reset      = 1'b1;

    repeat (2) @(negedge clk);
    bus.din   = 24'h804020;
    bus.de_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_dout", {8'h0, bus.dout}, 32'h0);
    chk("rst_sync", {29'b0, bus.hs_out, bus.vs_out, bus.de_out}, 32'h0);
    bus.de_in = 1'b0;
    reset = 1'b0;

    step(24'h804020, 1'b1, 1'b0, 1'b1, 24'h804020, "byp0");
    step(24'h123456, 1'b0, 1'b1, 1'b1, 24'h123456, "byp1");
    idle();
    step(24'hABCDEF, 1'b0, 1'b0, 1'b1, 24'hABCDEF, "byp2");
    step(24'hFFFFFF, 1'b1, 1'b1, 1'b1, 24'hFFFFFF, "byp3");
    idle();

    cmd(3'b011, 13'h004);
    cmd(3'b100, 13'd24);
    cmd(3'b101, 13'd8);
    cmd(3'b000, 13'h001);
    latch();
    step(24'hC0C0C0, 1'b1, 1'b1, 1'b1, 24'hFF6060, "gain_sat");
    step(24'h102030, 1'b1, 1'b1, 1'b1, 24'h181018, "gain_mix");
    step(24'hC0C0C0, 1'b1, 1'b1, 1'b1, 24'hFF6060, "en_pre");
    bus.enable = 1'b0;
    step(24'hC0C0C0, 1'b1, 1'b1, 1'b1, 24'hC0C0C0, "en_off");
    bus.enable = 1'b1;
    step(24'hC0C0C0, 1'b1, 1'b1, 1'b1, 24'hFF6060, "en_back");

    cmd(3'b011, 13'h00B);
    cmd(3'b100, 13'h11F);
    cmd(3'b101, 13'h100);
    latch();
    step(24'h808080, 1'b1, 1'b1, 1'b1, 24'h00F8F8, "grp1");

    cmd(3'b011, 13'h004);
    cmd(3'b011, 13'h012);
    cmd(3'b011, 13'h021);
    cmd(3'b100, 13'd16);
    cmd(3'b101, 13'd0);
    cmd(3'b010, 13'd2);
    cmd(3'b000, 13'h005);
    latch();
    step(24'hFFFFFF, 1'b0, 1'b1, 1'b0, 24'h0, "");
    for (int i = 0; i < 7; i++)
      step(24'hFFFFFF, 1'b0, 1'b1, 1'b1, pat3[i], "pat_scale2");

    for (int i = 1; i < 8; i++)
      cmd(3'b011, 13'(i << 4));
    cmd(3'b010, 13'd15);
    cmd(3'b000, 13'h001);
    latch();
    step(24'hFFFFFF, 1'b0, 1'b1, 1'b0, 24'h0, "");
    for (int i = 0; i < 9; i++)
      step(24'hFFFFFF, 1'b0, 1'b1, 1'b1,
           (i == 0 || i == 8) ? 24'hFF0000 : 24'h000000, "hmax_clamp");

    cmd(3'b011, 13'h012);
    cmd(3'b011, 13'h021);
    cmd(3'b010, 13'd2);
    cmd(3'b001, 13'd0);
    cmd(3'b000, 13'h003);
    latch();
    for (int i = 0; i < 18; i++)
      step(24'hFFFFFF, rot_h[i], rot_v[i], rot_c[i], rot_x[i], "rotate");

    cmd(3'b011, 13'h007);
    cmd(3'b010, 13'd0);
    cmd(3'b000, 13'h001);
    latch();
    step(24'h404040, 1'b1, 1'b1, 1'b1, 24'h404040, "fe_base");
    cmd(3'b100, 13'd8);
    step(24'h404040, 1'b1, 1'b1, 1'b1,
         LATCH ? 24'h404040 : 24'h202020, "fe_mid");
    bus.cmd_wr = 1'b1;
    bus.cmd_in = {3'b100, 13'd4};
    step(24'h404040, 1'b1, 1'b0, 1'b0, 24'h0, "");
    bus.cmd_wr = 1'b0;
    step(24'h404040, 1'b1, 1'b0, 1'b1,
         LATCH ? 24'h202020 : 24'h101010, "fe_frame1");
    idle();
    step(24'h404040, 1'b1, 1'b0, 1'b0, 24'h0, "");
    step(24'h404040, 1'b1, 1'b0, 1'b1, 24'h101010, "fe_frame2");

    repeat (4) idle();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/shadowmask_gen.md
Name: shadowmask_gen

Overview:
- Parametrised successor to the fixed 8-bit shadow mask stage; sits in the video output path after the scaler, before the HDMI/VGA output mux.
- Applies a programmable 2D mask pattern to RGB video: per-channel gain per pattern cell, rotation, and 1x..4x integer pattern scaling.
- Single clock domain: the command port runs on the video clock; the host-side CDC is external.

Parameters:
- CW, 8, bits per colour channel (4..12).
- MB, 3, log2 of max pattern dimension (1..4); pattern up to 2^MB x 2^MB cells, LUT depth 2^(2*MB).
- GW, 5, gain width; gain unit = 1/16, so default range 0..31/16.

Ports:
- clk  in  1  video pixel clock
- reset  in  1  asynchronous, active-high reset
- cmd_wr  in  1  command strobe, one command per cycle
- cmd_in  in  16  command word
- din  in  3*CW  {R,G,B}
- hs_in, vs_in, de_in  in  1 each  syncs / data enable
- enable  in  1  core-side mask allow
- dout  out  3*CW  masked {R,G,B}
- hs_out, vs_out, de_out  out  1 each  delayed syncs

Behaviour:
- Reset: dout=0, syncs out=0, all counters=0.
  - Config after reset: mask_enable=0, rotate=0, scale=1, hmax=vmax=0, both on gains=16, both off gains=16.
  - LUT is not reset; software loads it before enabling.
- Commands (opcode cmd_in[15:13]); each takes effect the cycle after cmd_wr:
  - 000: [0] mask_enable, [1] rotate, [3:2] scale-1.
  - 001: vmax = cmd_in[3:0] (pattern height-1). 010: hmax = cmd_in[3:0] (pattern width-1). Values above 2^MB-1 clamp to 2^MB-1.
  - 011: LUT[cmd_in[4+2*MB-1:4]] = cmd_in[3:0]. Entry = {grp, Ron, Gon, Bon}.
  - 100: on_gain[cmd_in[8]] = cmd_in[GW-1:0]. 101: off_gain[cmd_in[8]] = cmd_in[GW-1:0].
  - 110/111: ignored.
- Edge detection: hs_in and vs_in falling edges (1->0), detected against the previous-cycle registered value.
- Counters: hsub/vsub prescalers count 0..scale-1; hidx/vidx are pattern indices.
  - Every clk: hsub++. On hsub==scale-1: hsub=0, and hidx++ wrapping to 0 after HW.
  - hs falling edge: hsub=hidx=0; vsub++ (same wrap rule for vidx against VH).
  - vs falling edge: vsub=vidx=0.
  - hs and vs falling in the same cycle: vs wins for the vertical counters; the hs reset of the horizontal counters still applies.
- Rotation:
  - rotate=0: HW=hmax, VH=vmax, LUT addr={vidx,hidx}.
  - rotate=1: HW=vmax, VH=hmax, LUT addr={hidx,vidx}.
  - Config changes mid-line take effect immediately; if an index is now beyond the new max, it wraps to 0 on its next advance.
- Pipeline (fixed latency 4 clk for data and syncs, including while disabled):
  - C1: LUT read; register pixel and syncs.
  - C2: per channel, gain = on ? on_gain[grp] : off_gain[grp]. If !(mask_enable & enable), gain=16 for all channels. The enable term is registered, one cycle ahead of C2.
  - C3: product = chan * gain, CW+GW bits unsigned.
  - C4: out = product>>4, saturated to 2^CW-1. Drive dout and syncs.
- Disabled path is bit-exact: dout = din delayed 4 clk.

Optional Feature:
- Macro: SHADOWMASK_VSYNC_LATCH_EN.
- Defined:
  - Opcodes 000, 001, 010, 100 and 101 write shadow registers.
  - Active config is copied from shadow on the vs_in falling edge only.
  - A cmd_wr in the same cycle as that edge updates shadow only; it applies on the next frame.
  - LUT writes (011) remain immediate.
  - Reset sets shadow and active config to the same reset values.
- Undefined: all writes go directly to active config, as above.

Test Plan:
- Reset/bypass, CW=8: mask_enable=0, din=0x804020 -> dout=0x804020 exactly 4 clk later; hs/vs/de delayed 4 clk; dout=0 during reset.
- Gains: hmax=vmax=0, LUT[0]=4'b0100, on_gain[0]=24, off_gain[0]=8, enabled; din=0xC0C0C0 -> dout=0xFF6060 (R saturates from 0x120).
- Pattern/scale: hmax=2, scale=2, LUT[0..2]=R,G,B on (grp 0), on=16, off=0, din=0xFFFFFF -> after each hs falling edge, dout sequence R,R,G,G,B,B,R... (0xFF0000 x2, 0x00FF00 x2, 0x0000FF x2).
- Rotation: hmax=2, vmax=0, rotate=1 -> column pattern is constant along a line and advances R,G,B on successive lines; vs falling resets to R.
- Edge cases: hs and vs falling in the same cycle -> vidx=hidx=0. Writing hmax=15 with MB=3 -> wrap at 7. enable=0 while mask_enable=1 -> bypass, 2 clk after enable falls (registered enable, then C2).
- SHADOWMASK_VSYNC_LATCH_EN: write on_gain[0]=8 mid-frame -> output unchanged until vs falling edge, halved after it. A write coincident with the edge applies one frame later.
